muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS32 pipeline: executes MULT, MULTU, DIV and DIVU and holds the HI/LO result registers.
- Sits beside the single-cycle ALU in EX; the ALU has no multi-cycle path, so this unit takes over those operations.
- Uses a start/busy/done handshake so hazard logic can stall mfhi/mflo until done.

Parameters:
- WIDTH, 32, operand/HI/LO width. All test values assume 32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch an operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  multiplicand / dividend, sampled with start
- b  input  WIDTH  multiplier / divisor, sampled with start
- hi_we  input  1  mthi write enable
- lo_we  input  1  mtlo write enable
- wdata  input  WIDTH  mthi/mtlo data
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when HI/LO update
- div_by_zero  output  1  set with done when a DIV/DIVU had b==0; held until next accepted start
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, immediate): state=IDLE; hi, lo, counter and internal datapath = 0; busy=0, done=0, div_by_zero=0. Reset mid-operation abandons the operation with no HI/LO update.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - start=1 latches op, a and b, and clears div_by_zero.
  - Signed ops (MULT, DIV) convert operands to magnitudes and record the result signs.
  - For DIV/DIVU with b==0, go directly to DONE: hi<=a, lo<=all-ones, div_by_zero<=1. done is high the cycle after the start edge.
  - Otherwise go to CALC with counter=0.
- CALC: exactly WIDTH edges, one bit per edge.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, WIDTH+1-bit partial remainder, quotient shifted in from the LSB.
  - At counter==WIDTH-1, go to FIXUP.
- FIXUP (1 edge):
  - Apply signs. MULT negates the 2*WIDTH product when the operand signs differ. DIV negates the quotient when the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo: product upper/lower half, or remainder/quotient. Go to DONE.
- DONE (1 cycle): done=1, then IDLE on the next edge.
- Latency: start edge = E0; HI/LO written at E(WIDTH+1); done high during the cycle after E(WIDTH+1), i.e. until E(WIDTH+2). busy is high from after E0 through the DONE cycle.
- start while busy is ignored; no queueing. Operands must be re-presented after done.
- mthi/mtlo:
  - In IDLE with start=0, hi_we/lo_we write wdata on the edge; both may write in the same cycle.
  - Writes are dropped when busy, or when start=1 in the same cycle (start wins).
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, no flag; this falls out of the magnitude algorithm.
- hi/lo are stable outside the FIXUP/zero-divide write edge and the mthi/mtlo edge.
- No arithmetic exceptions are raised; div_by_zero is informational only.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 34 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 34 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5, b=0 -> done the cycle after start; hi=5, lo=0xFFFFFFFF, div_by_zero=1. A following DIVU 9/3 clears the flag and gives lo=3, hi=0.
- Start MULTU 2*3, pulse start with other operands and assert hi_we during CALC -> both ignored; result hi=0, lo=6. Then hi_we=1 and lo_we=1 with wdata=0x1234 in IDLE -> hi=lo=0x1234. start and lo_we together -> lo write dropped.
- Assert reset 10 cycles into CALC -> busy, done, hi, lo = 0 immediately without waiting for a clock edge; no done pulse follows. A new MULTU 4*5 after release -> lo=20.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit holding HI/LO.
// MULT/MULTU by shift-add, DIV/DIVU by restoring division, with a start/busy/done handshake.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               op_signed, op_div, zero_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    zero_div  = op_div && (b == '0);
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // Multiply: acc lower half holds the multiplier and shifts right as the
  // product grows in. Divide: acc lower half holds the dividend, which shifts
  // left into the remainder while quotient bits enter at the LSB.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand};
    rem_nx    = div_ge ? WIDTH'(div_shift - {1'b0, mcand}) : div_shift[WIDTH-1:0];
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE:    if (start) state_nx = zero_div ? DONE : CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_nx = FIXUP;
      FIXUP:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      mcand       <= '0;
      acc         <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op_div;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            div_by_zero <= zero_div;
            count       <= '0;
            rem         <= '0;
            mcand       <= b_mag;
            acc         <= {{WIDTH{1'b0}}, a_mag};
            if (zero_div) begin
              hi <= a;
              lo <= '1;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          count <= count + CW'(1);
          if (is_div) begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
            rem            <= rem_nx;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIXUP: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
